// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch slice: datapath widths, the canonical
// NOP encoding (addi x0,x0,0) and the fetch FSM state type.
// No ports.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    // REQ  : may issue a request
    // WAIT : one request outstanding, response will be used
    // FLUSH: one request outstanding, response will be dropped
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_reg.sv
// -----------------------------------------------------------------------------
// fetch_hold_reg
// One-entry holding register for a fetched instruction and its address.
// Its contents drive the fetch unit outputs directly.
//   clk, reset        : clock, asynchronous active-high reset
//   load              : capture load_pc/load_inst, set valid (wins over clear)
//   clear             : drop the entry; pc reads 0 and inst reads NOP
//   load_pc/load_inst : entry to capture
//   valid/pc/inst     : current entry
// -----------------------------------------------------------------------------
module fetch_hold_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [ILEN-1:0] load_inst,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] inst
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inst_q, inst_d;

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one
        // unassigned and infer a latch.
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            inst_d  = load_inst;
        end else if (clear) begin
            valid_d = 1'b0;
            pc_d    = '0;
            inst_d  = NOP_INST;
        end
    end

    // NOTE: non-blocking assignments in clocked logic so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: keeps at most one memory request in flight,
// buffers the returned word in a holding register and hands it to the IF/ID
// stage when if_id_write is high. Redirects restart fetch at a new target.
//   RESET_PC                       : first fetch address after reset
//   clk, reset                     : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      : request channel (addr word aligned)
//   imem_rsp_valid/data            : in-order response, one per request
//   if_id_write                    : downstream load enable (0 = stall)
//   redirect_valid/pc              : taken branch/jump target
//   inst_valid/pc_out/inst_out     : presented instruction (NOP when empty)
//   perf_fetched/perf_stall        : transfer and stall-cycle counters,
//                                    present only with FETCH_PERF_CNT_EN
// -----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            if_id_write,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_stall,
`endif
    output logic            inst_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [ILEN-1:0] inst_out
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ~64'd3;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic transfer;
    logic req_fire;
    logic hold_load;
    logic hold_clear;

    assign transfer = inst_valid && if_id_write;

    // Combinational so a request can go out in the same cycle the current
    // instruction is consumed; forced low while reset is held.
    assign imem_req_valid = !reset && (state_q == REQ) && (!inst_valid || if_id_write);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A redirect both blocks the capture and empties the register.
    assign hold_load  = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
    assign hold_clear = redirect_valid || transfer;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            REQ: begin
                // A request accepted under a redirect targets the old path.
                if (req_fire) state_d = redirect_valid ? FLUSH : WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                    if (!redirect_valid) fetch_pc_d = fetch_pc_q + 64'd4;
                end else if (redirect_valid) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_rsp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_pc & ~64'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC_ALIGNED;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_hold_reg u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_pc   (fetch_pc_q),
        .load_inst (imem_rsp_data),
        .valid     (inst_valid),
        .pc        (pc_out),
        .inst      (inst_out)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetched_q, perf_fetched_d;
    logic [63:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {63'd0, transfer};
        perf_stall_d   = perf_stall_q + {63'd0, inst_valid && !if_id_write};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed and randomized checks of fetch_unit. The memory is modelled as a
// single-outstanding responder with programmable latency; instruction words
// are a fixed function of the address so every presented word is predictable.
// A second instance starts at the top of the address space to show wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_write;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [63:0] pc_out;
    logic [31:0] inst_out;

    logic        w_req_valid;
    logic        w_req_ready;
    logic [63:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_if_id_write;
    logic        w_redirect_valid;
    logic [63:0] w_redirect_pc;
    logic        w_inst_valid;
    logic [63:0] w_pc_out;
    logic [31:0] w_inst_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
    endfunction

    fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_write    (if_id_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .pc_out         (pc_out),
        .inst_out       (inst_out)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .if_id_write    (w_if_id_write),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .inst_valid     (w_inst_valid),
        .pc_out         (w_pc_out),
        .inst_out       (w_inst_out)
    );

    // Main memory: latency (extra cycles beyond one) chosen at acceptance.
    int          mem_lat = 0;
    logic        pend;
    int          cnt;
    logic [63:0] pend_addr;

    assign imem_rsp_valid = pend && (cnt == 0);
    assign imem_rsp_data  = imem_rsp_valid ? inst_of(pend_addr) : 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            cnt       <= 0;
            pend_addr <= '0;
        end else if (imem_rsp_valid) begin
            pend <= 1'b0;
        end else if (pend) begin
            cnt <= cnt - 1;
        end else if (imem_req_valid && imem_req_ready) begin
            pend      <= 1'b1;
            cnt       <= mem_lat;
            pend_addr <= imem_req_addr;
        end
    end

    // Wrap-instance memory: always ready, always one cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= '0;
        end else begin
            w_rsp_valid <= w_req_valid && w_req_ready;
            w_rsp_data  <= inst_of(w_req_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Steps at least one cycle, then waits (bounded) for the next presented
    // instruction and checks it.
    task automatic expect_next(input string tag, input logic [63:0] pc);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!inst_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, inst_valid, 1);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_inst"}, inst_out, inst_of(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] prev_addr;
        logic        prev_pend;
        int          n_xfer;
        int          n;

        reset            = 1'b0;
        imem_req_ready   = 1'b1;
        if_id_write      = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        w_req_ready      = 1'b1;
        w_if_id_write    = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        #1 reset = 1'b1;

        // ---- reset state ----
        @(negedge clk); #1;
        check("rst_inst_valid", inst_valid, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_inst_out", inst_out, NOP);
        check("rst_req_valid", imem_req_valid, 0);
        @(negedge clk);

        // ---- basic sequence, two-cycle latency ----
        reset = 1'b0; #1;
        check("rel_req_valid", imem_req_valid, 1);
        check("rel_req_addr", imem_req_addr, 64'h1000);
        check("w_rel_req_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); #1;
        check("lat1_inst_valid", inst_valid, 0);
        @(negedge clk); #1;
        check("lat2_inst_valid", inst_valid, 1);
        check("seq0_pc", pc_out, 64'h1000);
        check("seq0_inst", inst_out, inst_of(64'h1000));
        check("w_first_pc", w_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        check("w_second_req_valid", w_req_valid, 1);
        check("w_second_req_addr", w_req_addr, 64'h0);
        expect_next("seq1", 64'h1004);

        // ---- downstream stall for five cycles ----
        if_id_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", inst_valid, 1);
            check("stall_pc", pc_out, 64'h1004);
            check("stall_inst", inst_out, inst_of(64'h1004));
            check("stall_no_req", imem_req_valid, 0);
            @(negedge clk);
        end
        if_id_write = 1'b1;
        expect_next("resume", 64'h1008);

        // ---- redirect while waiting, late response dropped ----
        mem_lat = 3;
        @(negedge clk); #1;
        check("wait_no_req", imem_req_valid, 0);
        check("wait_inst_valid", inst_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_lat        = 0;
        #1;
        check("flush_inst_valid", inst_valid, 0);
        check("flush_no_req", imem_req_valid, 0);
        expect_next("redir_wait", 64'h2000);

        // ---- redirect coincident with response ----
        @(negedge clk); #1;
        check("coinc_rsp_present", imem_rsp_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("coinc_inst_valid", inst_valid, 0);
        check("coinc_req_valid", imem_req_valid, 1);
        check("coinc_req_addr", imem_req_addr, 64'h3000);
        expect_next("redir_rsp", 64'h3000);

        // ---- randomized traffic against an address-sequence model ----
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = {32'h0, $urandom};
        exp_pc         = redirect_pc & ~64'd3;
        @(negedge clk);
        redirect_valid = 1'b0;
        prev_pend = 1'b0;
        prev_addr = '0;
        n_xfer    = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            if_id_write    = ($urandom_range(0, 9) < 7);
            mem_lat        = $urandom_range(0, 2);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = {($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h0, $urandom};
            #1;
            if (prev_pend && imem_req_valid)
                check("rand_addr_stable", imem_req_addr, prev_addr);
            if (imem_req_valid)
                check("rand_addr_align", {62'd0, imem_req_addr[1:0]}, 0);
            if (inst_valid && if_id_write) begin
                check("rand_pc", pc_out, exp_pc);
                check("rand_inst", inst_out, inst_of(exp_pc));
                exp_pc = exp_pc + 64'd4;
                n_xfer++;
            end else if (!inst_valid) begin
                check("rand_nop", inst_out, NOP);
            end
            if (redirect_valid) exp_pc = redirect_pc & ~64'd3;
            prev_pend = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr = imem_req_addr;
        end
        check("rand_progress", n_xfer >= 30, 1);

        // ---- reset while a request is outstanding ----
        @(negedge clk);
        imem_req_ready = 1'b1;
        if_id_write    = 1'b1;
        mem_lat        = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n = 0;
        while (!imem_req_valid && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check("pre_wait_req", imem_req_valid, 1);
        @(negedge clk); #1;
        check("in_wait_no_req", imem_req_valid, 0);
        reset = 1'b1; #1;
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_req_valid", imem_req_valid, 0);
        check("midrst_pc_out", pc_out, 0);
        check("midrst_inst_out", inst_out, NOP);
        mem_lat = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; #1;
        check("postrst_req_valid", imem_req_valid, 1);
        check("postrst_req_addr", imem_req_addr, 64'h1000);
        expect_next("postrst", 64'h1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
